// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module  : mux_scan_pkg
// Brief   : Shared types, sizes and the frame-slot helper for mux_scan_ctrl.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

  localparam int N_CH      = 4;
  localparam int DW        = 2;
  localparam int SEL_W     = $clog2(N_CH);
  localparam int DWELL_W   = 4;
  localparam int DWELL_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    SAMPLE  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  // Bit offset of channel k inside the packed frame.
  function automatic int slot_lsb(input int k);
    return k * DW;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// ============================================================================
// Module  : dwell_timer
// Brief   : Loadable down-counter that flags zero; holds at zero.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module dwell_timer
  import mux_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [DWELL_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - DWELL_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// Module  : mux_scan_ctrl
// Brief   : Round-robin scanner driving mux41_dual select and framing its output.
//           Optional per-slot change flags under MUX_SCAN_CHANGE_FLAG_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = DWELL_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cont,
  input  logic                 stop,
  output logic [SEL_W-1:0]     sel,
  input  logic [DW-1:0]        mux_f,
`ifdef MUX_SCAN_CHANGE_FLAG_EN
  output logic [N_CH-1:0]      changed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_CH*DW-1:0]   out_data,
  output logic                 busy
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             cont_q;
  logic             stop_seen_q;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic             capture;
  logic             handoff;
  logic [DW-1:0]    slot_q [N_CH];

  dwell_timer u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (DWELL_W'(DWELL - 1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    capture  = 1'b0;
    handoff  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          sel_d    = '0;
          tmr_load = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d = SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SAMPLE: begin
        capture = 1'b1;
        if (sel_q == SEL_W'(N_CH - 1)) begin
          state_d = PRESENT;
        end else begin
          sel_d    = sel_q + SEL_W'(1);
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          handoff = 1'b1;
          // A stop arriving on the handshake cycle itself also ends the run.
          if (cont_q && !stop_seen_q && !stop) begin
            sel_d    = '0;
            tmr_load = 1'b1;
            state_d  = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      cont_q <= cont;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_seen_q <= 1'b0;
    end else if (state_q == IDLE) begin
      stop_seen_q <= 1'b0;
    end else if (stop) begin
      stop_seen_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_q[k] <= '0;
      end else if (capture && (sel_q == SEL_W'(k))) begin
        slot_q[k] <= mux_f;
      end
    end
    assign out_data[slot_lsb(k) +: DW] = slot_q[k];
  end

`ifdef MUX_SCAN_CHANGE_FLAG_EN
  logic [DW-1:0]   last_q [N_CH];
  logic [N_CH-1:0] chg_q;

  // last_q holds the most recently handed-off frame, the reference for change flags.
  for (genvar k = 0; k < N_CH; k++) begin : g_chg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        last_q[k] <= '0;
        chg_q[k]  <= 1'b0;
      end else begin
        if (handoff) begin
          last_q[k] <= slot_q[k];
        end
        if (capture && (sel_q == SEL_W'(k))) begin
          chg_q[k] <= (mux_f != last_q[k]);
        end
      end
    end
  end

  assign changed = chg_q;
`endif

  assign sel       = sel_q;
  assign out_valid = (state_q == PRESENT);
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// ============================================================================
// Module  : tb_mux_scan_ctrl
// Brief   : Directed self-checking bench for mux_scan_ctrl with a 4:1 mux model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       stop = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] sel;
  logic [1:0] mux_f;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic [3:0] changed;
  logic [1:0] x0, x1, x2, x3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for mux41_dual: F = X[Y].
  always_comb begin
    case (sel)
      2'd0:    mux_f = x0;
      2'd1:    mux_f = x1;
      2'd2:    mux_f = x2;
      default: mux_f = x3;
    endcase
  end

  mux_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cont      (cont),
    .stop      (stop),
    .sel       (sel),
    .mux_f     (mux_f),
`ifdef MUX_SCAN_CHANGE_FLAG_EN
    .changed   (changed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

`ifndef MUX_SCAN_CHANGE_FLAG_EN
  assign changed = 4'b0000;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic c);
    start = 1'b1;
    cont  = c;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_sel", 32'(sel), 32'd0);
  endtask

  // Entered one step after the edge that began the frame. Runs the 16-cycle scan,
  // holds the frame for 'hold' cycles with out_ready low, then performs the handshake.
  task automatic scan_frame(input logic [7:0] exp_data, input logic [3:0] exp_chg,
                            input int hold, input bit poke, input int stop_at);
    for (int c = 1; c <= 16; c++) begin
      if (poke) begin
        out_ready = c[0];
        start     = (c == 5) || (c == 10);
      end
      stop = (c == stop_at);
      tick();
      if (c < 16) begin
        if ((c % 4) == 1) check("scan_sel", 32'(sel), 32'(c / 4));
        if (c == 15) check("scan_valid_low", 32'(out_valid), 32'd0);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    check("present_valid", 32'(out_valid), 32'd1);
    check("present_data", 32'(out_data), 32'(exp_data));
    check("present_sel", 32'(sel), 32'd3);
`ifdef MUX_SCAN_CHANGE_FLAG_EN
    check("present_changed", 32'(changed), 32'(exp_chg));
`endif
    out_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(exp_data));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("after_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    x0 = 2'b01; x1 = 2'b10; x2 = 2'b11; x3 = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();

    // Single shot, consumer always ready.
    out_ready = 1'b1;
    do_start(1'b0);
    scan_frame(8'h39, 4'b0111, 0, 1'b0, 0);
    check("s1_busy", 32'(busy), 32'd0);
    check("s1_data_kept", 32'(out_data), 32'h39);

    // Single shot, consumer stalls five cycles.
    do_start(1'b0);
    scan_frame(8'h39, 4'b0000, 5, 1'b0, 0);
    check("s2_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a scan.
    do_start(1'b0);
    repeat (8) tick();
    check("s4_sel_pre", 32'(sel), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("s4_sel", 32'(sel), 32'd0);
    check("s4_valid", 32'(out_valid), 32'd0);
    check("s4_data", 32'(out_data), 32'd0);
    check("s4_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    do_start(1'b0);
    scan_frame(8'h39, 4'b0111, 0, 1'b0, 0);
    check("s4_end_busy", 32'(busy), 32'd0);

    // Continuous run, channel 2 changes between frames, stop during frame 2.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    do_start(1'b1);
    scan_frame(8'h39, 4'b0111, 2, 1'b0, 0);
    x2 = 2'b01;
    check("s3_cont_busy", 32'(busy), 32'd1);
    check("s3_cont_sel", 32'(sel), 32'd0);
    scan_frame(8'h19, 4'b0100, 1, 1'b0, 6);
    check("s3_end_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    check("s3_no_frame3", 32'(out_valid), 32'd0);
    check("s3_idle", 32'(busy), 32'd0);

    // Spurious start and out_ready pulses during the scan.
    do_start(1'b0);
    scan_frame(8'h19, 4'b0000, 0, 1'b1, 0);
    check("s5_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("s5_still_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
